// File: rtl/ihp13_sram_bist_ctrl_if.sv
// BIST port group between the March C- sequencer and one IHP SG13 single-port SRAM macro.
interface ihp13_sram_bist_ctrl_if #(
  parameter int unsigned NumWords  = 256,
  parameter int unsigned DataWidth = 64
);
  localparam int unsigned AddrWidth = $clog2(NumWords);

  logic                 bist_en_o;
  logic                 bist_men_o;
  logic                 bist_wen_o;
  logic                 bist_ren_o;
  logic [AddrWidth-1:0] bist_addr_o;
  logic [DataWidth-1:0] bist_din_o;
  logic [DataWidth-1:0] bist_bm_o;
  logic [DataWidth-1:0] bist_dout_i;

  modport master (
    output bist_en_o, bist_men_o, bist_wen_o, bist_ren_o,
    output bist_addr_o, bist_din_o, bist_bm_o,
    input  bist_dout_i
  );

  modport slave (
    input  bist_en_o, bist_men_o, bist_wen_o, bist_ren_o,
    input  bist_addr_o, bist_din_o, bist_bm_o,
    output bist_dout_i
  );
endinterface

// File: rtl/ihp13_sram_bist_ctrl.sv
// March C- self-test sequencer for one IHP SG13 single-port SRAM macro; one op per cycle,
// read data checked one cycle later, first mismatch latched.
module ihp13_sram_bist_ctrl #(
  parameter int unsigned  NumWords  = 256,
  parameter int unsigned  DataWidth = 64,
  localparam int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   fail_o,
  output logic [AddrWidth-1:0]   fail_addr_o,
  output logic [2:0]             fail_elem_o,
  ihp13_sram_bist_ctrl_if.master bist
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

  state_e               state_reg, state_next;
  logic [2:0]           elem_reg, elem_next;
  logic                 phase_reg, phase_next;
  logic [AddrWidth-1:0] addr_reg, addr_next;
  logic                 cmp_valid_reg, cmp_valid_next;
  logic                 cmp_bg_reg, cmp_bg_next;
  logic [AddrWidth-1:0] cmp_addr_reg, cmp_addr_next;
  logic [2:0]           cmp_elem_reg, cmp_elem_next;
  logic                 fail_reg, fail_next;
  logic [AddrWidth-1:0] fail_addr_reg, fail_addr_next;
  logic [2:0]           fail_elem_reg, fail_elem_next;

  logic op_active, op_read, op_bg, last_phase, dir_down, addr_end, mismatch;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      elem_reg      <= '0;
      phase_reg     <= 1'b0;
      addr_reg      <= '0;
      cmp_valid_reg <= 1'b0;
      cmp_bg_reg    <= 1'b0;
      cmp_addr_reg  <= '0;
      cmp_elem_reg  <= '0;
      fail_reg      <= 1'b0;
      fail_addr_reg <= '0;
      fail_elem_reg <= '0;
    end else begin
      state_reg     <= state_next;
      elem_reg      <= elem_next;
      phase_reg     <= phase_next;
      addr_reg      <= addr_next;
      cmp_valid_reg <= cmp_valid_next;
      cmp_bg_reg    <= cmp_bg_next;
      cmp_addr_reg  <= cmp_addr_next;
      cmp_elem_reg  <= cmp_elem_next;
      fail_reg      <= fail_next;
      fail_addr_reg <= fail_addr_next;
      fail_elem_reg <= fail_elem_next;
    end
  end

  always_comb begin
    op_active  = (state_reg == RUN);
    op_read    = (elem_reg != 3'd0) && !phase_reg;
    // E1..E4 read the background the previous element left and write its complement
    op_bg      = (elem_reg != 3'd0) && (elem_reg != 3'd5) &&
                 (((elem_reg == 3'd2) || (elem_reg == 3'd4)) ^ phase_reg);
    last_phase = phase_reg || (elem_reg == 3'd0) || (elem_reg == 3'd5);
    dir_down   = (elem_reg >= 3'd3);
    addr_end   = dir_down ? (addr_reg == '0) : (addr_reg == LastAddr);
    mismatch   = cmp_valid_reg && (bist.bist_dout_i != {DataWidth{cmp_bg_reg}});

    state_next     = state_reg;
    elem_next      = elem_reg;
    phase_next     = phase_reg;
    addr_next      = addr_reg;
    cmp_valid_next = 1'b0;
    cmp_bg_next    = cmp_bg_reg;
    cmp_addr_next  = cmp_addr_reg;
    cmp_elem_next  = cmp_elem_reg;
    fail_next      = fail_reg;
    fail_addr_next = fail_addr_reg;
    fail_elem_next = fail_elem_reg;

    unique case (state_reg)
      IDLE, DONE: begin
        if (start_i) begin
          state_next     = RUN;
          elem_next      = '0;
          phase_next     = 1'b0;
          addr_next      = '0;
          fail_next      = 1'b0;
          fail_addr_next = '0;
          fail_elem_next = '0;
        end
      end
      RUN: begin
        cmp_valid_next = op_read;
        cmp_bg_next    = op_bg;
        cmp_addr_next  = addr_reg;
        cmp_elem_next  = elem_reg;
        if (!last_phase) begin
          phase_next = 1'b1;
        end else begin
          phase_next = 1'b0;
          if (!addr_end) begin
            addr_next = dir_down ? addr_reg - AddrWidth'(1) : addr_reg + AddrWidth'(1);
          end else if (elem_reg == 3'd5) begin
            state_next = DRAIN;
          end else begin
            elem_next = elem_reg + 3'd1;
            addr_next = (elem_reg >= 3'd2) ? LastAddr : '0;
          end
        end
        if (mismatch) begin
          state_next     = DONE;
          cmp_valid_next = 1'b0;
          fail_next      = 1'b1;
          fail_addr_next = cmp_addr_reg;
          fail_elem_next = cmp_elem_reg;
        end
      end
      DRAIN: begin
        state_next = DONE;
        if (mismatch) begin
          fail_next      = 1'b1;
          fail_addr_next = cmp_addr_reg;
          fail_elem_next = cmp_elem_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_o      = (state_reg == RUN) || (state_reg == DRAIN);
  assign done_o      = (state_reg == DONE);
  assign fail_o      = fail_reg;
  assign fail_addr_o = fail_addr_reg;
  assign fail_elem_o = fail_elem_reg;

  assign bist.bist_en_o   = busy_o;
  assign bist.bist_men_o  = op_active;
  assign bist.bist_wen_o  = op_active && !op_read;
  assign bist.bist_ren_o  = op_active && op_read;
  assign bist.bist_addr_o = op_active ? addr_reg : '0;
  assign bist.bist_din_o  = (op_active && !op_read) ? {DataWidth{op_bg}} : '0;
  assign bist.bist_bm_o   = op_active ? '1 : '0;

  a_elem_range: assert property (@(posedge clk_i) disable iff (!rst_ni) elem_reg <= 3'd5);

endmodule

// File: tb/tb_ihp13_sram_bist_ctrl.sv
// Bench for the March C- sequencer: two configurations, behavioural macro with injectable
// faults, and a March-table reference model checked against the DUT every cycle.
module tb_ihp13_sram_bist_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       start_a = '0;
  logic [1:0]       rstn_a  = '1;
  logic [1:0]       busy_a, done_a, fail_a, en_a, men_a;
  logic [1:0][10:0] addr_a, fail_addr_a;
  logic [1:0][2:0]  fail_elem_a;

  int stuck_addr [2] = '{-1, -1};
  int stuck_bit  [2] = '{0, 0};
  int stuck_val  [2] = '{1, 1};
  int corrupt_k  [2] = '{-1, -1};

  int checks   = 0;
  int failures = 0;

  logic [63:0] pmem [2048];
  int          addr_trace [20600];

  // March C- as a table: ops per address, direction, value read, value written
  int march_nops [6] = '{1, 2, 2, 2, 2, 1};
  bit march_up   [6] = '{1, 1, 1, 0, 0, 0};
  bit march_rd   [6] = '{0, 0, 1, 0, 1, 0};
  bit march_wr   [6] = '{0, 1, 0, 1, 0, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void op_at(input int n, input int k, output int e, output int a,
                                output bit wr, output bit bg);
    int rem, p, idx;
    rem = k; e = 5; a = 0; wr = 1'b0; bg = 1'b0;
    for (int el = 0; el < 6; el++) begin
      if (rem >= 0 && rem < n * march_nops[el]) begin
        e   = el;
        p   = rem % march_nops[el];
        idx = rem / march_nops[el];
        a   = march_up[el] ? idx : n - 1 - idx;
        wr  = (el == 0) || (p == 1);
        bg  = wr ? march_wr[el] : march_rd[el];
      end
      rem -= n * march_nops[el];
    end
  endfunction

  // Op index of the first failing read, or -1 for a clean pass
  function automatic int predict(input int n, input int sa, input int sb, input int sv, input int ck);
    int e, a;
    bit wr, bg;
    logic [63:0] v;
    for (int k = 0; k < 10 * n; k++) begin
      if (k == ck) pmem[0][0] = ~pmem[0][0];
      op_at(n, k, e, a, wr, bg);
      if (wr) begin
        pmem[a] = {64{bg}};
      end else begin
        v = pmem[a];
        if (a == sa) v[sb] = sv[0];
        if (v != {64{bg}}) return k;
      end
    end
    return -1;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int N  = (gi == 0) ? 256 : 2048;
    localparam int W  = (gi == 0) ? 64 : 48;
    localparam int AW = $clog2(N);
    localparam logic [63:0] Mask = {64{1'b1}} >> (64 - W);

    ihp13_sram_bist_ctrl_if #(.NumWords(N), .DataWidth(W)) bif ();
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;

    ihp13_sram_bist_ctrl #(.NumWords(N), .DataWidth(W)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rstn_a[gi]),
      .start_i     (start_a[gi]),
      .busy_o      (busy),
      .done_o      (done),
      .fail_o      (fail),
      .fail_addr_o (fail_addr),
      .fail_elem_o (fail_elem),
      .bist        (bif)
    );

    assign busy_a[gi]      = busy;
    assign done_a[gi]      = done;
    assign fail_a[gi]      = fail;
    assign en_a[gi]        = bif.bist_en_o;
    assign men_a[gi]       = bif.bist_men_o;
    assign addr_a[gi]      = 11'(bif.bist_addr_o);
    assign fail_addr_a[gi] = 11'(fail_addr);
    assign fail_elem_a[gi] = fail_elem;

    logic [W-1:0] mem [N];
    int           mop_cnt = 0;

    function automatic logic [W-1:0] faulty(input logic [W-1:0] v, input int a);
      logic [W-1:0] r;
      r = v;
      if (a == stuck_addr[gi]) r[stuck_bit[gi]] = stuck_val[gi][0];
      return r;
    endfunction

    always @(posedge clk) begin
      if (bif.bist_men_o) begin
        mop_cnt <= mop_cnt + 1;
        if (bif.bist_wen_o) mem[bif.bist_addr_o] <= bif.bist_din_o & bif.bist_bm_o;
        if (bif.bist_ren_o) bif.bist_dout_i <= faulty(mem[bif.bist_addr_o], int'(bif.bist_addr_o));
      end else if (!busy) begin
        mop_cnt <= 0;
      end
      if (mop_cnt == corrupt_k[gi]) mem[0][0] <= ~mem[0][0];
    end

    initial begin : p_cmp
      bit          run, m_done, m_fail, wr, bg;
      int          c, fk, t_end, m_faddr, m_felem, e, a;
      logic [6:0]  exp_ctrl;
      logic [63:0] exp_addr, exp_din, exp_bm;
      run = 0; m_done = 0; m_fail = 0; m_faddr = 0; m_felem = 0;
      c = 0; fk = -1; t_end = 0;
      forever begin
        @(negedge clk);
        if (!rstn_a[gi]) begin
          run = 0; m_done = 0; m_fail = 0; m_faddr = 0; m_felem = 0;
        end
        exp_addr = '0; exp_din = '0; exp_bm = '0;
        if (run) begin
          if (c <= 10 * N && c < t_end) begin
            op_at(N, c - 1, e, a, wr, bg);
            exp_addr = 64'(a);
            exp_din  = wr ? ({64{bg}} & Mask) : '0;
            exp_bm   = Mask;
            exp_ctrl = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, wr, !wr};
          end else begin
            exp_ctrl = 7'b1001000;
          end
        end else begin
          exp_ctrl = {1'b0, m_done, m_fail, 4'b0000};
        end
        check($sformatf("i%0d_ctrl", gi),
              64'({busy, done, fail, bif.bist_en_o, bif.bist_men_o, bif.bist_wen_o, bif.bist_ren_o}),
              64'(exp_ctrl));
        check($sformatf("i%0d_addr", gi), 64'(bif.bist_addr_o), exp_addr);
        check($sformatf("i%0d_din", gi), 64'(bif.bist_din_o), exp_din);
        check($sformatf("i%0d_bm", gi), 64'(bif.bist_bm_o), exp_bm);
        check($sformatf("i%0d_fail_addr", gi), 64'(fail_addr), 64'(m_faddr));
        check($sformatf("i%0d_fail_elem", gi), 64'(fail_elem), 64'(m_felem));

        @(posedge clk);
        if (!rstn_a[gi]) begin
          run = 0; m_done = 0; m_fail = 0; m_faddr = 0; m_felem = 0;
        end else if (run) begin
          c++;
          if (c == t_end) begin
            run    = 0;
            m_done = 1;
            m_fail = (fk >= 0);
            if (fk >= 0) begin
              op_at(N, fk, e, a, wr, bg);
              m_faddr = a;
              m_felem = e;
            end
          end
        end else if (start_a[gi]) begin
          run = 1; c = 1;
          fk = predict(N, stuck_addr[gi], stuck_bit[gi], stuck_val[gi], corrupt_k[gi]);
          t_end = (fk >= 0) ? fk + 3 : 10 * N + 2;
          m_done = 0; m_fail = 0; m_faddr = 0; m_felem = 0;
        end
      end
    end
  end

  task automatic wait_done(input int i, input int limit, output int n_cyc,
                           output int busy_c, output int men_c);
    n_cyc = -1; busy_c = 0; men_c = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c < 20600) addr_trace[c] = int'(addr_a[i]);
      if (busy_a[i]) busy_c++;
      if (men_a[i]) men_c++;
      if (done_a[i]) begin
        n_cyc = c;
        break;
      end
    end
    check($sformatf("i%0d_done_seen", i), 64'(n_cyc > 0), 64'd1);
  endtask

  task automatic run_one(input int i, input int n, input bit hold,
                         output int dc, output int bc, output int mc);
    @(posedge clk);
    #2 start_a[i] = 1'b1;
    @(posedge clk);
    #2;
    if (!hold) start_a[i] = 1'b0;
    wait_done(i, 10 * n + 8, dc, bc, mc);
  endtask

  initial begin : p_main
    int dc, bc, mc, sa, sb, sv;
    #1 rstn_a = '0;
    repeat (3) @(posedge clk);
    #2 rstn_a = '1;
    @(negedge clk);
    check("reset_done", 64'(done_a[0]), 64'd0);
    check("reset_busy", 64'(busy_a[0]), 64'd0);

    // clean pass, N=256
    run_one(0, 256, 1'b0, dc, bc, mc);
    check("t1_busy_cycles", 64'(bc), 64'd2561);
    check("t1_done_cycle", 64'(dc), 64'd2562);
    check("t1_men_cycles", 64'(mc), 64'd2560);
    check("t1_fail", 64'(fail_a[0]), 64'd0);

    // bit 3 of word 5 stuck at 1: caught by the E1 r0 at cycle 267
    stuck_addr[0] = 5; stuck_bit[0] = 3; stuck_val[0] = 1;
    run_one(0, 256, 1'b0, dc, bc, mc);
    check("t2_done_cycle", 64'(dc), 64'd269);
    check("t2_fail", 64'(fail_a[0]), 64'd1);
    check("t2_fail_elem", 64'(fail_elem_a[0]), 64'd1);
    check("t2_fail_addr", 64'(fail_addr_a[0]), 64'd5);
    stuck_addr[0] = -1;

    // word 0 bit 0 flipped after E4: only the last E5 read sees it, in DRAIN
    corrupt_k[0] = 9 * 256;
    run_one(0, 256, 1'b0, dc, bc, mc);
    check("t3_done_cycle", 64'(dc), 64'd2562);
    check("t3_fail", 64'(fail_a[0]), 64'd1);
    check("t3_fail_elem", 64'(fail_elem_a[0]), 64'd5);
    check("t3_fail_addr", 64'(fail_addr_a[0]), 64'd0);
    corrupt_k[0] = -1;

    // start held high: first run fails in E2 at word 7, then restarts right after done
    stuck_addr[0] = 7; stuck_bit[0] = 10; stuck_val[0] = 0;
    run_one(0, 256, 1'b1, dc, bc, mc);
    check("t4_done_cycle", 64'(dc), 64'd785);
    check("t4_busy_cycles", 64'(bc), 64'd784);
    check("t4_fail_elem", 64'(fail_elem_a[0]), 64'd2);
    check("t4_fail_addr", 64'(fail_addr_a[0]), 64'd7);
    stuck_addr[0] = -1;
    @(negedge clk);
    check("t4_restart_busy", 64'(busy_a[0]), 64'd1);
    check("t4_restart_done", 64'(done_a[0]), 64'd0);
    check("t4_restart_fail", 64'(fail_a[0]), 64'd0);
    start_a[0] = 1'b0;
    wait_done(0, 2600, dc, bc, mc);
    check("t4_rerun_done", 64'(dc), 64'd2561);
    check("t4_rerun_fail", 64'(fail_a[0]), 64'd0);

    // asynchronous reset mid-test
    @(posedge clk);
    #2 start_a[0] = 1'b1;
    @(posedge clk);
    #2 start_a[0] = 1'b0;
    repeat (1000) @(negedge clk);
    check("t5_busy_before", 64'(busy_a[0]), 64'd1);
    #1 rstn_a[0] = 1'b0;
    #1;
    check("t5_async_outputs",
          64'({busy_a[0], done_a[0], fail_a[0], en_a[0], men_a[0], addr_a[0], fail_elem_a[0]}), 64'd0);
    @(posedge clk);
    #2 rstn_a[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_idle_after", 64'({busy_a[0], done_a[0], men_a[0]}), 64'd0);

    // random stuck-at faults: stuck-1 shows in E1 r0, stuck-0 in E2 r1
    for (int r = 0; r < 4; r++) begin
      sa = int'($urandom_range(0, 255));
      sb = int'($urandom_range(0, 63));
      sv = int'($urandom_range(0, 1));
      stuck_addr[0] = sa; stuck_bit[0] = sb; stuck_val[0] = sv;
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run_one(0, 256, 1'b0, dc, bc, mc);
      check("rnd_fail_elem", 64'(fail_elem_a[0]), (sv == 1) ? 64'd1 : 64'd2);
      check("rnd_fail_addr", 64'(fail_addr_a[0]), 64'(sa));
      check("rnd_done_cycle", 64'(dc), 64'(((sv == 1) ? 256 : 768) + 2 * sa + 3));
    end
    stuck_addr[0] = -1;

    // N=2048, W=48: full pass and element-boundary address wraps
    run_one(1, 2048, 1'b0, dc, bc, mc);
    check("t6_done_cycle", 64'(dc), 64'd20482);
    check("t6_men_cycles", 64'(mc), 64'd20480);
    check("t6_fail", 64'(fail_a[1]), 64'd0);
    check("t6_up_last", 64'(addr_trace[2048]), 64'd2047);
    check("t6_up_wrap", 64'(addr_trace[2049]), 64'd0);
    check("t6_down_last", 64'(addr_trace[7 * 2048]), 64'd0);
    check("t6_down_wrap", 64'(addr_trace[7 * 2048 + 1]), 64'd2047);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
